// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command path.
//  - 4-bit command codes driven on calc_top.cmd
//  - status_t: encoding of calc_top.status (2'b11 is treated as BUSY by users)
//  - sched_state_t: calc_cmd_scheduler FSM states
//  - sched_cnt_w(): counter width able to hold the largest timing parameter
package calc_pkg;

    localparam logic [3:0] CMD_D0    = 4'd0;
    localparam logic [3:0] CMD_D1    = 4'd1;
    localparam logic [3:0] CMD_D2    = 4'd2;
    localparam logic [3:0] CMD_D3    = 4'd3;
    localparam logic [3:0] CMD_D4    = 4'd4;
    localparam logic [3:0] CMD_D5    = 4'd5;
    localparam logic [3:0] CMD_D6    = 4'd6;
    localparam logic [3:0] CMD_D7    = 4'd7;
    localparam logic [3:0] CMD_D8    = 4'd8;
    localparam logic [3:0] CMD_D9    = 4'd9;
    localparam logic [3:0] CMD_ADD   = 4'b1010;
    localparam logic [3:0] CMD_SUB   = 4'b1011;
    localparam logic [3:0] CMD_MUL   = 4'b1100;
    localparam logic [3:0] CMD_NOP   = 4'b1101;
    localparam logic [3:0] CMD_EQ    = 4'b1110;
    localparam logic [3:0] CMD_CLEAR = 4'b1111;

    typedef enum logic [1:0] {
        READY = 2'b00,
        BUSY  = 2'b01,
        ERROR = 2'b10
    } status_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        GAP   = 2'b10,
        WAIT  = 2'b11
    } sched_state_t;

    function automatic int unsigned sched_cnt_w(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin arbiter with an eligibility mask.
//  i_req   [1:0]  request bits, bit0 = key, bit1 = host
//  i_mask  [1:0]  1 = requester may be granted this cycle
//  i_last         source of the previous grant (0 key, 1 host)
//  o_gnt   [1:0]  one-hot grant (combinational), 0 when nothing eligible
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    logic [1:0] w_elig;

    assign w_elig = i_req & i_mask;

    // On a tie the source that did not win last time goes first.
    always_comb begin
        o_gnt = w_elig;
        if (w_elig == 2'b11)
            o_gnt = i_last ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/calc_cmd_scheduler.sv
// Shares calc_top.cmd between the keypad and host requesters. A granted
// command is held for HOLD_CYCLES, then NOP for GAP_CYCLES, then the
// scheduler waits for calc_top.status to leave BUSY (bounded by TIMEOUT)
// before the next grant.
//  i_clk / i_rst_n            clock, async active-low reset
//  i_key_valid/i_key_cmd      keypad request, o_key_ready 1-cycle accept pulse
//  i_host_valid/i_host_cmd    host request,   o_host_ready 1-cycle accept pulse
//  i_calc_status              calc_top.status (11 treated as BUSY)
//  o_calc_cmd                 to calc_top.cmd
//  o_busy                     not in IDLE
//  o_err_flag / o_timeout     sticky flags, cleared by a granted CMD_CLEAR
//  o_last_src                 source of the last grant (0 key, 1 host)
// All outputs are registered. The ready pulse and the first cycle of the
// command on o_calc_cmd both appear on the cycle after the IDLE decision.
module calc_cmd_scheduler
    import calc_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_valid,
    input  logic [3:0] i_key_cmd,
    output logic       o_key_ready,
    input  logic       i_host_valid,
    input  logic [3:0] i_host_cmd,
    output logic       o_host_ready,
    input  logic [1:0] i_calc_status,
    output logic [3:0] o_calc_cmd,
    output logic       o_busy,
    output logic       o_err_flag,
    output logic       o_timeout,
    output logic       o_last_src
);

    localparam int unsigned CW = sched_cnt_w(HOLD_CYCLES, GAP_CYCLES, TIMEOUT);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    sched_state_t r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_calc_cmd;
    logic          r_key_ready;
    logic          r_host_ready;
    logic          r_busy;
    logic          r_err;
    logic          r_timeout;
    logic          r_last_src;

    logic [1:0] w_req;
    logic [1:0] w_mask;
    logic [1:0] w_gnt;
    logic [3:0] w_gnt_cmd;

    assign w_req = {i_host_valid, i_key_valid};

    // With an error outstanding only a CLEAR may pass; a blocked request
    // from one side must not starve a CLEAR from the other.
    assign w_mask = r_err ? {i_host_cmd == CMD_CLEAR, i_key_cmd == CMD_CLEAR}
                          : 2'b11;

    rr_arb2 u_arb (
        .i_req  (w_req),
        .i_mask (w_mask),
        .i_last (r_last_src),
        .o_gnt  (w_gnt)
    );

    assign w_gnt_cmd = w_gnt[1] ? i_host_cmd : i_key_cmd;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_calc_cmd   <= CMD_NOP;
            r_key_ready  <= 1'b0;
            r_host_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_timeout    <= 1'b0;
            r_last_src   <= 1'b1;
        end else begin
            r_key_ready  <= 1'b0;
            r_host_ready <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_key_ready  <= w_gnt[0];
                        r_host_ready <= w_gnt[1];
                        r_last_src   <= w_gnt[1];
                        r_calc_cmd   <= w_gnt_cmd;
                        if (w_gnt_cmd == CMD_CLEAR) begin
                            r_err     <= 1'b0;
                            r_timeout <= 1'b0;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_calc_cmd <= CMD_NOP;
                        r_cnt      <= '0;
                        r_state    <= GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    // READY beats ERROR beats timeout; 2'b11 falls through as BUSY.
                    if (i_calc_status == READY) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (i_calc_status == ERROR) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt == WAIT_LAST) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_key_ready  = r_key_ready;
    assign o_host_ready = r_host_ready;
    assign o_calc_cmd   = r_calc_cmd;
    assign o_busy       = r_busy;
    assign o_err_flag   = r_err;
    assign o_timeout    = r_timeout;
    assign o_last_src   = r_last_src;

endmodule

// File: tb/tb_calc_cmd_scheduler.sv
// Bench for calc_cmd_scheduler: reset values, a table of single-grant
// transactions, hand-written multi-cycle corner sequences, then a random
// run against a grant-relative timing model.
module tb_calc_cmd_scheduler;
    import calc_pkg::*;

    localparam int H  = 10;
    localparam int G  = 4;
    localparam int TO = 1024;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       kv    = 1'b0;
    logic       hv    = 1'b0;
    logic [3:0] kc    = 4'd0;
    logic [3:0] hc    = 4'd0;
    logic [1:0] st    = 2'b00;
    logic       key_rdy, host_rdy, busy, err, tmo, last;
    logic [3:0] ccmd;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    calc_cmd_scheduler #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .TIMEOUT(TO)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_key_valid   (kv),
        .i_key_cmd     (kc),
        .o_key_ready   (key_rdy),
        .i_host_valid  (hv),
        .i_host_cmd    (hc),
        .o_host_ready  (host_rdy),
        .i_calc_status (st),
        .o_calc_cmd    (ccmd),
        .o_busy        (busy),
        .o_err_flag    (err),
        .o_timeout     (tmo),
        .o_last_src    (last)
    );

    typedef struct {
        logic       kv;
        logic [3:0] kc;
        logic       hv;
        logic [3:0] hc;
        logic [1:0] st;
        int         exp_src;
        logic [3:0] exp_cmd;
        logic       exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Returns the granted source (-1 if none within the bound) and the
    // number of negedges from the call to the ready pulse.
    task automatic wait_ready(output int src, output int lat);
        src = -1;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (key_rdy || host_rdy) begin
                src = host_rdy ? 1 : 0;
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int lim, output int n);
        n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (busy) n = -1;
    endtask

    function automatic logic [3:0] rcmd();
        if ($urandom_range(0, 4) == 0) return CMD_CLEAR;
        return 4'($urandom_range(0, 15));
    endfunction

    // Random phase. The model tracks only "cycles since the ready pulse":
    // the command shows for the first H of them, NOP afterwards, and from
    // offset H+G onward the calc status decides when service ends.
    task automatic run_random(input int ncyc);
        logic       m_act, m_err, m_tmo, m_last, m_src, done, ke, he, src;
        logic [3:0] m_cmd;
        int         m_k, kage, hage;
        logic [9:0] expv, actv;
        m_act = 1'b0; m_err = 1'b0; m_tmo = 1'b0; m_last = 1'b1;
        m_src = 1'b0; m_cmd = CMD_NOP; m_k = 0; kage = 0; hage = 0;
        expv = {1'b0, 1'b0, CMD_NOP, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < ncyc && errs < 20; c++) begin
            @(negedge clk);
            actv = {key_rdy, host_rdy, ccmd, busy, err, tmo, last};
            chk($sformatf("rand_cyc%0d", c), 32'(actv), 32'(expv));
            // requesters: hold until ready, occasionally give up on a stuck request
            if (kv && (key_rdy || kage > 40)) begin kv = 1'b0; kage = 0; end
            else if (kv) kage++;
            else if ($urandom_range(0, 3) == 0) begin kv = 1'b1; kc = rcmd(); end
            if (hv && (host_rdy || hage > 40)) begin hv = 1'b0; hage = 0; end
            else if (hv) hage++;
            else if ($urandom_range(0, 3) == 0) begin hv = 1'b1; hc = rcmd(); end
            case ($urandom_range(0, 19)) inside
                [0:11]:  st = 2'b00;
                [12:15]: st = 2'b01;
                [16:17]: st = 2'b10;
                default: st = 2'b11;
            endcase
            if (!m_act) begin
                ke = kv && (!m_err || kc == CMD_CLEAR);
                he = hv && (!m_err || hc == CMD_CLEAR);
                if (ke || he) begin
                    src    = (ke && he) ? !m_last : he;
                    m_act  = 1'b1;
                    m_k    = 0;
                    m_src  = src;
                    m_last = src;
                    m_cmd  = src ? hc : kc;
                    if (m_cmd == CMD_CLEAR) begin m_err = 1'b0; m_tmo = 1'b0; end
                end
            end else begin
                done = 1'b0;
                if (m_k >= H + G) begin
                    if (st == 2'b00) done = 1'b1;
                    else if (st == 2'b10) begin m_err = 1'b1; done = 1'b1; end
                    else if (m_k - H - G == TO - 1) begin m_tmo = 1'b1; done = 1'b1; end
                end
                if (done) m_act = 1'b0;
                else m_k++;
            end
            if (m_act)
                expv = {m_k == 0 && !m_src, m_k == 0 && m_src,
                        (m_k < H) ? m_cmd : CMD_NOP, 1'b1, m_err, m_tmo, m_last};
            else
                expv = {1'b0, 1'b0, CMD_NOP, 1'b0, m_err, m_tmo, m_last};
        end
    endtask

    initial begin
        int src, lat, n, cnt1, nbusy, npulse, first_nop, first_idle;

        tbl[0] = '{1'b1, CMD_D2,  1'b1, CMD_ADD,   2'b00, 0, CMD_D2,  1'b0};
        tbl[1] = '{1'b1, CMD_D3,  1'b1, CMD_SUB,   2'b00, 1, CMD_SUB, 1'b0};
        tbl[2] = '{1'b0, CMD_D0,  1'b1, CMD_MUL,   2'b00, 1, CMD_MUL, 1'b0};
        tbl[3] = '{1'b1, CMD_EQ,  1'b1, CMD_D7,    2'b10, 0, CMD_EQ,  1'b1};
        tbl[4] = '{1'b1, CMD_D4,  1'b1, CMD_CLEAR, 2'b00, 1, CMD_CLEAR, 1'b0};
        tbl[5] = '{1'b1, CMD_D9,  1'b0, CMD_D0,    2'b00, 0, CMD_D9,  1'b0};

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_calc_cmd", 32'(ccmd), 32'(CMD_NOP));
        chk("rst_busy", 32'(busy), 0);
        chk("rst_key_ready", 32'(key_rdy), 0);
        chk("rst_host_ready", 32'(host_rdy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_timeout", 32'(tmo), 0);
        chk("rst_last_src", 32'(last), 1);
        rst_n = 1'b1;

        // table of single-grant transactions
        foreach (tbl[i]) begin
            kv = tbl[i].kv; kc = tbl[i].kc; hv = tbl[i].hv; hc = tbl[i].hc; st = tbl[i].st;
            wait_ready(src, lat);
            kv = 1'b0; hv = 1'b0;
            chk($sformatf("tbl%0d_src", i), 32'(src), 32'(tbl[i].exp_src));
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 1);
            chk($sformatf("tbl%0d_cmd", i), 32'(ccmd), 32'(tbl[i].exp_cmd));
            chk($sformatf("tbl%0d_last", i), 32'(last), 32'(tbl[i].exp_src));
            wait_idle(200, n);
            st = 2'b00;
            chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
        end

        // key cmd 1: one ready pulse, cmd for H cycles, NOP for G, one WAIT cycle
        kv = 1'b1; kc = CMD_D1; st = 2'b00;
        wait_ready(src, lat);
        kv = 1'b0;
        chk("t1_src", 32'(src), 0);
        cnt1 = 0; nbusy = 0; npulse = 0; first_nop = -1; first_idle = -1;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) @(negedge clk);
            if (ccmd == CMD_D1) cnt1++;
            else if (first_nop < 0) first_nop = i;
            if (busy) nbusy++;
            else if (first_idle < 0) first_idle = i;
            if (key_rdy || host_rdy) npulse++;
        end
        chk("t1_cmd_cycles", 32'(cnt1), H);
        chk("t1_first_nop", 32'(first_nop), H);
        chk("t1_first_idle", 32'(first_idle), H + G + 1);
        chk("t1_busy_cycles", 32'(nbusy), H + G + 1);
        chk("t1_ready_pulses", 32'(npulse), 1);

        // status BUSY for 30 cycles holds off a pending host request
        kv = 1'b1; kc = CMD_D6; st = 2'b01;
        wait_ready(src, lat);
        kv = 1'b0; hv = 1'b1; hc = CMD_D8;
        npulse = 0; nbusy = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (host_rdy || key_rdy) npulse++;
            if (busy) nbusy++;
        end
        chk("t3_no_grant_busy", 32'(npulse), 0);
        chk("t3_busy_held", 32'(nbusy), 30);
        st = 2'b00;
        wait_ready(src, lat);
        hv = 1'b0;
        chk("t3_src", 32'(src), 1);
        chk("t3_ready_after_status", 32'(lat), 2);
        chk("t3_cmd", 32'(ccmd), 32'(CMD_D8));
        wait_idle(100, n);

        // ERROR: host 5 stays pending, key CLEAR bypasses it, then host 5 served
        kv = 1'b1; kc = CMD_D1; st = 2'b10;
        wait_ready(src, lat);
        kv = 1'b0;
        wait_idle(100, n);
        st = 2'b00;
        chk("t4_err_set", 32'(err), 1);
        hv = 1'b1; hc = CMD_D5;
        npulse = 0; nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (host_rdy) npulse++;
            if (busy) nbusy++;
        end
        chk("t4_host_blocked", 32'(npulse), 0);
        chk("t4_stays_idle", 32'(nbusy), 0);
        kv = 1'b1; kc = CMD_CLEAR;
        wait_ready(src, lat);
        kv = 1'b0;
        chk("t4_clear_src", 32'(src), 0);
        chk("t4_clear_lat", 32'(lat), 1);
        chk("t4_err_cleared", 32'(err), 0);
        wait_ready(src, lat);
        hv = 1'b0;
        chk("t4_host_src", 32'(src), 1);
        chk("t4_host_cmd", 32'(ccmd), 32'(CMD_D5));
        wait_idle(100, n);

        // stuck BUSY (encoded 2'b11) until the WAIT bound expires
        kv = 1'b1; kc = CMD_D2; st = 2'b11;
        wait_ready(src, lat);
        kv = 1'b0;
        wait_idle(TO + 100, n);
        chk("t5_busy_cycles", 32'(n), H + G + TO);
        chk("t5_timeout", 32'(tmo), 1);
        chk("t5_err", 32'(err), 0);
        st = 2'b00;
        kv = 1'b1; kc = CMD_CLEAR;
        wait_ready(src, lat);
        kv = 1'b0;
        chk("t5_clear_src", 32'(src), 0);
        chk("t5_timeout_cleared", 32'(tmo), 0);
        wait_idle(100, n);

        // async reset in the middle of DRIVE
        kv = 1'b1; kc = CMD_EQ;
        wait_ready(src, lat);
        kv = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_pre_cmd", 32'(ccmd), 32'(CMD_EQ));
        chk("t6_pre_last", 32'(last), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_cmd", 32'(ccmd), 32'(CMD_NOP));
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_flags", 32'({err, tmo}), 0);
        chk("t6_rst_last", 32'(last), 1);
        @(negedge clk);
        rst_n = 1'b1;
        hv = 1'b1; hc = CMD_D3;
        wait_ready(src, lat);
        hv = 1'b0;
        chk("t6_after_src", 32'(src), 1);
        chk("t6_after_lat", 32'(lat), 1);
        chk("t6_after_cmd", 32'(ccmd), 32'(CMD_D3));
        wait_idle(100, n);
        chk("t6_after_busy_cycles", 32'(n), H + G + 1);

        // random traffic from a fresh reset
        kv = 1'b0; hv = 1'b0; st = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_random(3000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
